// File: rtl/inelastic_pipe_ctrl.sv
// Valid/ready sequencer for a chain of inelastic stage registers.
// Optional stall counter: define INELASTIC_PIPE_CTRL_STATS_EN.
module inelastic_pipe_ctrl #(
  parameter int depth_p = 3,
  localparam int count_width_p = $clog2(depth_p+1)
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic                     flush_i,
  output logic [depth_p-1:0]       en_o,
  output logic [count_width_p-1:0] count_o,
  output logic [31:0]              stall_cnt_o
);

  logic [depth_p-1:0]       v_q, v_d;
  logic [depth_p-1:0]       rdy, in_v;
  logic [count_width_p-1:0] cnt_q, cnt_d;
  logic                     full_above;
  logic                     in_xfer, out_xfer;

  // rdy[k] is low only when stages k..last are all full and the sink stalls
  always_comb begin
    full_above = 1'b1;
    rdy        = '0;
    for (int k = depth_p-1; k >= 0; k--) begin
      full_above = full_above & v_q[k];
      rdy[k]     = ~full_above | ready_i;
    end
  end

  always_comb begin
    in_v    = '0;
    in_v[0] = valid_i;
    for (int k = 1; k < depth_p; k++) begin
      in_v[k] = v_q[k-1];
    end
  end

  assign en_o     = rdy & in_v & {depth_p{~flush_i}};
  assign ready_o  = rdy[0] & ~flush_i;
  assign valid_o  = v_q[depth_p-1];
  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;
  assign count_o  = cnt_q;

  always_comb begin
    v_d   = (rdy & in_v) | (~rdy & v_q);
    cnt_d = cnt_q + count_width_p'(in_xfer)
                  - count_width_p'(out_xfer);
    if (flush_i) begin
      v_d   = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      v_q   <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef INELASTIC_PIPE_CTRL_STATS_EN
  logic [31:0] stall_q, stall_d;

  // saturating; only reset clears it, flush leaves it alone
  always_comb begin
    stall_d = stall_q;
    if (valid_o && !ready_i && !(&stall_q)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_inelastic_pipe_ctrl.sv
// Directed bench for inelastic_pipe_ctrl at depth 3,
// with a small shadow datapath driven by en_o.
module tb_inelastic_pipe_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        valid_i, ready_i, flush_i;
  logic        ready_o, valid_o;
  logic [2:0]  en_o;
  logic [1:0]  count_o;
  logic [31:0] stall_cnt_o;

  logic [7:0]  din;
  logic [7:0]  d0, d1, d2;

  int total = 0;
  int bad   = 0;

`ifdef INELASTIC_PIPE_CTRL_STATS_EN
  localparam logic [31:0] STALL5 = 32'd5;
`else
  localparam logic [31:0] STALL5 = 32'd0;
`endif

  inelastic_pipe_ctrl #(.depth_p(3)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .flush_i     (flush_i),
    .en_o        (en_o),
    .count_o     (count_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (en_o[0]) d0 <= din;
    if (en_o[1]) d1 <= d0;
    if (en_o[2]) d2 <= d1;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_ni = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    flush_i  = 1'b0;
    din      = 8'd0;
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_en", 32'(en_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_stall", stall_cnt_o, 32'd0);
    tick();
    tick();
    reset_ni = 1'b1;

    // streaming
    valid_i = 1'b1;
    ready_i = 1'b1;
    din     = 8'd1;
    #1;
    chk("str_en0", 32'(en_o), 32'h1);
    tick();
    chk("str_v1", 32'(valid_o), 32'd0);
    chk("str_c1", 32'(count_o), 32'd1);
    din = 8'd2;
    tick();
    chk("str_v2", 32'(valid_o), 32'd0);
    chk("str_c2", 32'(count_o), 32'd2);
    din = 8'd3;
    tick();
    chk("str_v3", 32'(valid_o), 32'd1);
    chk("str_c3", 32'(count_o), 32'd3);
    chk("str_d3", 32'(d2), 32'd1);
    chk("str_en3", 32'(en_o), 32'h7);
    chk("str_rdy3", 32'(ready_o), 32'd1);
    din = 8'd4;
    tick();
    chk("str_c4", 32'(count_o), 32'd3);
    chk("str_d4", 32'(d2), 32'd2);

    // drain
    valid_i = 1'b0;
    tick();
    tick();
    tick();
    chk("drn_c", 32'(count_o), 32'd0);
    chk("drn_v", 32'(valid_o), 32'd0);

    // backpressure fill
    ready_i = 1'b0;
    valid_i = 1'b1;
    din     = 8'd10;
    tick();
    din = 8'd11;
    #1;
    chk("bp_en1", 32'(en_o), 32'h3);
    tick();
    din = 8'd12;
    chk("bp_rdy2", 32'(ready_o), 32'd1);
    tick();
    chk("bp_rdy3", 32'(ready_o), 32'd0);
    chk("bp_c3", 32'(count_o), 32'd3);
    chk("bp_en3", 32'(en_o), 32'h0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    #1;
    chk("bp_rdy_rel", 32'(ready_o), 32'd1);
    chk("bp_en_rel", 32'(en_o), 32'h6);
    chk("bp_d_rel", 32'(d2), 32'd10);
    tick();
    ready_i = 1'b0;
    chk("bp_c_after", 32'(count_o), 32'd2);
    chk("bp_d_after", 32'(d2), 32'd11);

    // flush with two beats held
    flush_i = 1'b1;
    valid_i = 1'b1;
    #1;
    chk("fl_en", 32'(en_o), 32'h0);
    chk("fl_rdy", 32'(ready_o), 32'd0);
    chk("fl_vo", 32'(valid_o), 32'd1);
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("fl_c", 32'(count_o), 32'd0);
    chk("fl_v", 32'(valid_o), 32'd0);

    // bubble collapse: A, idle, B under stall
    valid_i = 1'b1;
    din     = 8'd20;
    tick();
    valid_i = 1'b0;
    tick();
    valid_i = 1'b1;
    din     = 8'd21;
    tick();
    valid_i = 1'b0;
    chk("bub_c", 32'(count_o), 32'd2);
    chk("bub_v101", 32'(valid_o), 32'd1);
    #1;
    chk("bub_en", 32'(en_o), 32'h2);
    tick();
    chk("bub_en_hold", 32'(en_o), 32'h0);
    chk("bub_rdy", 32'(ready_o), 32'd1);
    tick();
    chk("bub_c2", 32'(count_o), 32'd2);
    ready_i = 1'b1;
    #1;
    chk("bub_dA", 32'(d2), 32'd20);
    tick();
    chk("bub_vB", 32'(valid_o), 32'd1);
    chk("bub_dB", 32'(d2), 32'd21);
    tick();
    chk("bub_vend", 32'(valid_o), 32'd0);
    chk("bub_cend", 32'(count_o), 32'd0);

    // async reset mid-stream
    valid_i = 1'b1;
    din     = 8'd30;
    tick();
    tick();
    tick();
    tick();
    chk("ar_pre", 32'(count_o), 32'd3);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("ar_v", 32'(valid_o), 32'd0);
    chk("ar_c", 32'(count_o), 32'd0);
    chk("ar_rdy", 32'(ready_o), 32'd1);
    tick();
    reset_ni = 1'b1;
    din = 8'd40;
    tick();
    din = 8'd41;
    tick();
    din = 8'd42;
    tick();
    chk("ar_rst_v", 32'(valid_o), 32'd1);
    chk("ar_rst_d", 32'(d2), 32'd40);

    // stall statistics from a fresh reset
    reset_ni = 1'b0;
    #1;
    chk("st_rst0", stall_cnt_o, 32'd0);
    tick();
    reset_ni = 1'b1;
    ready_i  = 1'b0;
    valid_i  = 1'b1;
    tick();
    tick();
    tick();
    valid_i = 1'b0;
    chk("st_full", 32'(count_o), 32'd3);
    chk("st_zero", stall_cnt_o, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("st_five", stall_cnt_o, STALL5);
    flush_i = 1'b1;
    ready_i = 1'b1;
    tick();
    flush_i = 1'b0;
    ready_i = 1'b0;
    chk("st_flush", stall_cnt_o, STALL5);
    chk("st_flc", 32'(count_o), 32'd0);
    tick();
    chk("st_idle", stall_cnt_o, STALL5);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("st_rst", stall_cnt_o, 32'd0);
    tick();
    reset_ni = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
